// File: rtl/dct_zigzag_quant.sv
// dct_zigzag_quant: captures one DCT_val x DCT_val block of 13-bit signed DCT
// coefficients, quantizes each by 2^QSHIFT and streams the block out in JPEG
// zigzag order, one coefficient per accepted valid/ready handshake.
//
// Build option: QUANT_ROUND_EN
//   defined   -> round to nearest, half away from zero
//   undefined -> arithmetic shift (floor toward -inf)
//
// state  | meaning
// IDLE   | waiting for a block; in_ready high
// STREAM | presenting coefficient k of the buffered block; out_valid high
module dct_zigzag_quant #(
    parameter int DCT_val = 4,
    parameter int QSHIFT  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [DCT_val-1:0][DCT_val-1:0][12:0]     coef_in,
    input  logic                                      coef_valid,
    output logic                                      in_ready,
    output logic [12:0]                               out_coef,
    output logic [$clog2(DCT_val*DCT_val)-1:0]        out_index,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_last
);

    localparam int NN = DCT_val * DCT_val;
    localparam int KW = $clog2(NN);
    localparam int RW = $clog2(DCT_val);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                                  state_q, state_d;
    logic [DCT_val-1:0][DCT_val-1:0][12:0]   blk_q, blk_d;
    logic [KW-1:0]                           k_q, k_d;
    logic [RW-1:0]                           row_q, row_d, col_q, col_d;
    logic [RW-1:0]                           row_nx, col_nx;
    logic                                    is_last;
    logic [12:0]                             sel;
    logic signed [13:0]                      x_ext;
    logic [12:0]                             q_val;

    // Zigzag walk: the current (row,col) alone determines the next position.
    // Even anti-diagonals move up-right, odd ones move down-left; at an edge
    // the walk steps onto the next diagonal.
    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
        if ((row_q[0] ^ col_q[0]) == 1'b0) begin
            if (col_q == RW'(DCT_val - 1)) begin
                row_nx = row_q + 1'b1;
            end else if (row_q == '0) begin
                col_nx = col_q + 1'b1;
            end else begin
                row_nx = row_q - 1'b1;
                col_nx = col_q + 1'b1;
            end
        end else begin
            if (row_q == RW'(DCT_val - 1)) begin
                col_nx = col_q + 1'b1;
            end else if (col_q == '0) begin
                row_nx = row_q + 1'b1;
            end else begin
                row_nx = row_q + 1'b1;
                col_nx = col_q - 1'b1;
            end
        end
    end

    assign sel   = blk_q[row_q][col_q];
    assign x_ext = {sel[12], sel};

`ifdef QUANT_ROUND_EN
    localparam int          HS   = (QSHIFT > 0) ? QSHIFT - 1 : 0;
    localparam logic [13:0] HALF = (QSHIFT > 0) ? (14'd1 << HS) : 14'd0;
    logic [13:0] mag, rnd;

    // Round the magnitude, then restore the sign (half away from zero).
    // 14 bits hold |-4096| + half without overflow.
    always_comb begin
        mag   = x_ext[13] ? -x_ext : x_ext;
        rnd   = (mag + HALF) >> QSHIFT;
        q_val = x_ext[13] ? 13'(-$signed(rnd)) : 13'(rnd);
    end
`else
    assign q_val = 13'(x_ext >>> QSHIFT);
`endif

    assign is_last   = (state_q == STREAM) && (k_q == KW'(NN - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_last  = is_last;
    assign out_index = k_q;
    assign out_coef  = (state_q == STREAM) ? q_val : 13'd0;

    // Next-state: capture a block in IDLE, advance the zigzag walk on each transfer.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (coef_valid) begin
                    blk_d   = coef_in;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (is_last) begin
                        k_d     = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else begin
                        k_d   = k_q + 1'b1;
                        row_d = row_nx;
                        col_d = col_nx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, buffer and walk registers; reset discards any partial block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// Directed testbench for dct_zigzag_quant (N=4, QSHIFT=2 main instance, plus
// N=2 instances at QSHIFT=0 and QSHIFT=12 for the extreme values).
// Expected values follow QUANT_ROUND_EN when it is defined for the build.
module tb_dct_zigzag_quant;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic [3:0][3:0][12:0]   coef_in;
    logic                    coef_valid, in_ready, out_valid, out_ready, out_last;
    logic [12:0]             out_coef;
    logic [3:0]              out_index;

    logic [1:0][1:0][12:0]   coef2;
    logic                    cv2, rdy2;
    logic                    ir1, ov1, ol1, ir2, ov2, ol2;
    logic [12:0]             oc1, oc2;
    logic [1:0]              oi1, oi2;

    dct_zigzag_quant #(.DCT_val(4), .QSHIFT(2)) dut (
        .clk(clk), .reset(reset), .coef_in(coef_in), .coef_valid(coef_valid),
        .in_ready(in_ready), .out_coef(out_coef), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

    dct_zigzag_quant #(.DCT_val(2), .QSHIFT(0)) dut_q0 (
        .clk(clk), .reset(reset), .coef_in(coef2), .coef_valid(cv2),
        .in_ready(ir1), .out_coef(oc1), .out_index(oi1),
        .out_valid(ov1), .out_ready(rdy2), .out_last(ol1));

    dct_zigzag_quant #(.DCT_val(2), .QSHIFT(12)) dut_q12 (
        .clk(clk), .reset(reset), .coef_in(coef2), .coef_valid(cv2),
        .in_ready(ir2), .out_coef(oc2), .out_index(oi2),
        .out_valid(ov2), .out_ready(rdy2), .out_last(ol2));

    typedef struct {
        int val [16];   // block input, index r*4+c
        int exp [16];   // expected out_coef per zigzag index
    } vec_t;

    vec_t vt [3];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int vi);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                coef_in[r][c] = 13'(vt[vi].val[r*4+c]);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after acceptance.
    task automatic send(input int vi);
        check("in_ready_before_load", int'(in_ready), 1);
        load(vi);
        coef_valid = 1'b1;
        @(negedge clk);
        coef_valid = 1'b0;
    endtask

    // Drains one block; bp toggles out_ready 1,0,0,1; pulse drives junk blocks with coef_valid.
    task automatic stream(input int vi, input bit bp, input bit pulse);
        int k;
        int cyc;
        bit rd;
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            rd = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            out_ready = rd;
            if (pulse) begin
                coef_valid = (cyc % 3 == 1);
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        coef_in[r][c] = 13'd777;
            end
            check("out_valid", int'(out_valid), 1);
            check("out_index", int'(out_index), k);
            check("out_coef", int'($signed(out_coef)), vt[vi].exp[k]);
            check("out_last", int'(out_last), (k == 15) ? 1 : 0);
            if (rd) k++;
            cyc++;
            @(negedge clk);
        end
        out_ready  = 1'b1;
        coef_valid = 1'b0;
        check("stream_done_in_budget", k, 16);
        check("in_ready_after_block", int'(in_ready), 1);
        check("out_valid_after_block", int'(out_valid), 0);
        check("out_last_after_block", int'(out_last), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e1 [4];
        int e2 [4];
        int acc;
        int p;

        // Vector 0: coef[r][c] = 4*(4r+c), exact multiples so both modes agree.
        for (int i = 0; i < 16; i++) vt[0].val[i] = 4 * i;
        vt[0].exp = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

        // Vector 1: rounding case, 6/-6/-5 at (0,0),(0,1),(1,0).
        for (int i = 0; i < 16; i++) begin
            vt[1].val[i] = 0;
            vt[1].exp[i] = 0;
        end
        vt[1].val[0] = 6;
        vt[1].val[1] = -6;
        vt[1].val[4] = -5;
`ifdef QUANT_ROUND_EN
        vt[1].exp[0] = 2;  vt[1].exp[1] = -2; vt[1].exp[2] = -1;
`else
        vt[1].exp[0] = 1;  vt[1].exp[1] = -2; vt[1].exp[2] = -2;
`endif

        // Vector 2: mixed signs and extremes scattered across the block.
        for (int i = 0; i < 16; i++) begin
            vt[2].val[i] = 0;
            vt[2].exp[i] = 0;
        end
        vt[2].val[3]  = -1;      // (0,3) -> k6
        vt[2].val[5]  = 2;       // (1,1) -> k4
        vt[2].val[8]  = -2;      // (2,0) -> k3
        vt[2].val[10] = 7;       // (2,2) -> k11
        vt[2].val[12] = -4096;   // (3,0) -> k9
        vt[2].val[15] = 4095;    // (3,3) -> k15
`ifdef QUANT_ROUND_EN
        vt[2].exp[6] = 0;  vt[2].exp[4] = 1;  vt[2].exp[3] = -1;
        vt[2].exp[11] = 2; vt[2].exp[9] = -1024; vt[2].exp[15] = 1024;
        e2 = '{-1, 1, -1, 0};
`else
        vt[2].exp[6] = -1; vt[2].exp[4] = 0;  vt[2].exp[3] = -1;
        vt[2].exp[11] = 1; vt[2].exp[9] = -1024; vt[2].exp[15] = 1023;
        e2 = '{-1, 0, -1, 0};
`endif
        e1 = '{-4096, 4095, -2048, 2047};

        // Reset values
        reset      = 1'b0;
        coef_valid = 1'b0;
        out_ready  = 1'b1;
        cv2        = 1'b0;
        rdy2       = 1'b1;
        coef_in    = '0;
        coef2      = '0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_coef", int'(out_coef), 0);
        check("rst_out_index", int'(out_index), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Extremes on the N=2 instances: QSHIFT=0 passthrough and QSHIFT=12.
        coef2[0][0] = 13'h1000;  // -4096
        coef2[0][1] = 13'h0FFF;  //  4095
        coef2[1][0] = 13'h1800;  // -2048
        coef2[1][1] = 13'h07FF;  //  2047
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("q0_valid", int'(ov1), 1);
            check("q0_index", int'(oi1), k);
            check("q0_coef", int'($signed(oc1)), e1[k]);
            check("q0_last", int'(ol1), (k == 3) ? 1 : 0);
            check("q12_coef", int'($signed(oc2)), e2[k]);
            check("q12_valid", int'(ov2), 1);
            @(negedge clk);
        end
        check("q0_idle_after", int'(ir1), 1);
        check("q12_idle_after", int'(ir2), 1);

        // Table-driven blocks at full throughput.
        for (int vi = 0; vi < 3; vi++) begin
            send(vi);
            stream(vi, 1'b0, 1'b0);
        end

        // Backpressure, with junk coef_valid pulses during STREAM.
        send(0);
        stream(0, 1'b1, 1'b1);
        send(2);
        stream(2, 1'b1, 1'b0);

        // Reset after the 5th transfer.
        send(0);
        for (int k = 0; k < 5; k++) begin
            check("pre_reset_index", int'(out_index), k);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_out_coef", int'(out_coef), 0);
        check("midrst_out_index", int'(out_index), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(2);
        stream(2, 1'b0, 1'b0);

        // Back-to-back: new block offered every cycle; accepts land N*N+1 apart.
        acc = 0;
        for (int cyc = 0; cyc < 51; cyc++) begin
            load(cyc % 3);
            coef_valid = 1'b1;
            p = cyc % 17;
            if (p == 0) begin
                check("b2b_in_ready", int'(in_ready), 1);
                check("b2b_idle_valid", int'(out_valid), 0);
                acc = cyc % 3;
            end else begin
                check("b2b_valid", int'(out_valid), 1);
                check("b2b_index", int'(out_index), p - 1);
                check("b2b_coef", int'($signed(out_coef)), vt[acc].exp[p-1]);
                check("b2b_last", int'(out_last), (p == 16) ? 1 : 0);
            end
            @(negedge clk);
        end
        coef_valid = 1'b0;
        check("b2b_final_idle", int'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dct_zigzag_quant.md
# dct_zigzag_quant

Downstream stage of the 2-D DCT: captures one DCT_val×DCT_val block of 13-bit signed coefficients, quantizes each by a power-of-two step, and streams the block out serially in zigzag order with a valid/ready handshake. It feeds the entropy/run-length coder and converts the DCT's parallel matrix result into a one-coefficient-per-cycle stream.

## Interface
- DCT_val, 4: block dimension N; legal values 2, 4, 8.
- QSHIFT, 2: quantization step is 2^QSHIFT; legal range 0..12.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- coef_in  input  [12:0] [DCT_val-1:0][DCT_val-1:0]  parallel coefficient block, two's-complement, indexed [row][col].
- coef_valid  input  1  block present on coef_in; sampled on clk.
- in_ready  output  1  block can be accepted this cycle.
- out_coef  output  13  quantized coefficient, two's-complement.
- out_index  output  $clog2(DCT_val*DCT_val)  zigzag position of out_coef, 0-based.
- out_valid  output  1  out_coef, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the current coefficient.
- out_last  output  1  current coefficient is the final one of the block.

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. When coef_valid=1, register the whole coef_in into the block buffer, clear the zigzag counter, and go to STREAM.
- STREAM: in_ready=0; coef_valid is ignored. out_valid=1. out_coef = Q(buffer[zz_row(k)][zz_col(k)]); out_index=k. The values hold stable until the handshake completes.
- Handshake: a transfer occurs when out_valid and out_ready are both 1. On a transfer, k increments. On the transfer with k=N²−1, the state returns to IDLE.
- out_last=1 exactly when in STREAM and k=N²−1.
- Zigzag order follows the JPEG convention generalized to N, starting (0,0)→(0,1)→(1,0)→(2,0)→(1,1)→(0,2). The full order for N=4 is (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),(2,1),(3,0),(3,1),(2,2),(1,3),(2,3),(3,2),(3,3).
- Quantization Q(x):
  - x is extended to 14 bits before any add, so there is no overflow.
  - The result is truncated back to 13 bits and always fits.
  - If QSHIFT=0, Q(x)=x and the rounding mode is irrelevant.
- Reset, including mid-stream: the state goes to IDLE, k=0, and the buffer is cleared to 0. Any partially streamed block is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_coef=0, out_index=0.
- Latency: if coef_valid is accepted at edge E, then out_valid=1 with k=0 is registered at E, so it is visible in the cycle following E.
- Throughput: one coefficient per cycle when out_ready is held at 1.
  - A block occupies N² STREAM cycles plus one IDLE cycle.
  - There is no overlap: the next block cannot be accepted on the same edge as the last transfer.
- out_coef, out_index, out_valid and out_last are registered outputs or decoded directly from registered state. There is no combinational path from out_ready or coef_valid to any output.
- out_ready low stalls indefinitely; all outputs stay stable during a stall.

## Configuration
- QUANT_ROUND_EN defined: round-to-nearest, half away from zero.
  - x≥0: Q=(x+2^(QSHIFT−1))>>QSHIFT.
  - x<0: Q=−((−x+2^(QSHIFT−1))>>QSHIFT).
- QUANT_ROUND_EN undefined: Q = x>>>QSHIFT, an arithmetic shift that floors toward −∞.

## Test plan
- Zigzag order, N=4, QSHIFT=2, out_ready=1: coef[r][c]=4·(4r+c) → out_coef sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15. out_index runs 0..15. out_last is high only on the value 15, then in_ready=1 on the next cycle.
- Rounding, QSHIFT=2, with the inputs 6, −6 and −5 placed at (0,0), (0,1) and (1,0):
  - With QUANT_ROUND_EN: 2, −2, −1.
  - Without QUANT_ROUND_EN: 1, −2, −2.
- Extremes, QSHIFT=0: −4096 and 4095 pass through unchanged. With QSHIFT=12 and rounding enabled, 4095→1 and −4096→−1.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly. Each coefficient appears exactly once and stays stable while out_ready=0. coef_valid pulses during STREAM are ignored and leave the buffer unchanged.
- Reset mid-stream: assert reset after the 5th transfer. All outputs return to their reset values immediately. The next accepted block streams from index 0 with the new data.
- Back-to-back: hold coef_valid=1 with a new block each cycle. Blocks are accepted only in IDLE, and each streams completely with the correct data, N²+1 cycles apart.
